// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall scheduler for the 5-stage pipeline. It merges the ID load-use
//   stall request with multi-cycle divide sequencing in EX, and drives the stall
//   bus seen by PC/IF/ID/EX/MEM/WB. It launches the external iterative divider,
//   holds the front of the pipe until the divider finishes, then releases it.
//
//   Optional feature macro: HAZ_PERF_EN. When it is defined, the block includes
//   the stall performance counters. When it is undefined, the perf ports are
//   tied to 0.
//
// Ports
//   clk             clock
//   rst             synchronous, active-high reset; all outputs read 0 while high
//   stallreq_id     ID load-use hazard (combinational, same cycle)
//   ex_div_req      instruction in EX is div/divu (level)
//   div_ready       divider result valid (pulse or level)
//   div_start       1-cycle pulse that launches the divider
//   div_busy        high while waiting on the divider
//   div_timeout     sticky flag: a divide hit DIV_TIMEOUT
//   stall[5:0]      bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = stage holds
//   perf_load_stall cycles with the LOAD stall pattern
//   perf_div_stall  cycles with the DIV stall pattern
module pipe_hazard_ctrl #(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 7,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              ex_div_req,
    input  logic              div_ready,
    output logic              div_start,
    output logic              div_busy,
    output logic              div_timeout,
    output logic [5:0]        stall,
    output logic [PERF_W-1:0] perf_load_stall,
    output logic [PERF_W-1:0] perf_div_stall
);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_LOAD = 6'b000111;  // PC/IF/ID hold, EX gets bubble
    localparam logic [5:0] STALL_DIV  = 6'b001111;  // PC..EX hold, MEM gets bubble

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    logic [5:0]       stall_c;
    logic             start_c;

    // State sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_div_req) begin
                        state <= DIV_WAIT;
                        cnt   <= '0;
                    end
                end
                DIV_WAIT: begin
                    // Saturate rather than wrap, so the timeout compare stays valid.
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    // A late div_ready still wins over the timeout on the same cycle.
                    if (div_ready) begin
                        state <= DIV_DONE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= DIV_DONE;
                    end
                end
                DIV_DONE: state <= IDLE;  // the divide leaves EX at this edge
                default:  state <= IDLE;
            endcase
        end
    end

    // Stall pattern and divider launch. Both are combinational, so the divider
    // starts on the first cycle the divide is seen in EX.
    always_comb begin
        stall_c = STALL_NONE;
        start_c = 1'b0;
        case (state)
            IDLE: begin
                if (ex_div_req) begin
                    stall_c = STALL_DIV;
                    start_c = 1'b1;
                end else if (stallreq_id) begin
                    stall_c = STALL_LOAD;
                end
            end
            DIV_WAIT: stall_c = STALL_DIV;
            // ex_div_req here is still the divide that just finished.
            DIV_DONE: stall_c = stallreq_id ? STALL_LOAD : STALL_NONE;
            default:  stall_c = STALL_NONE;
        endcase
    end

    assign stall       = rst ? STALL_NONE : stall_c;
    assign div_start   = ~rst & start_c;
    assign div_busy    = ~rst & (state == DIV_WAIT);
    assign div_timeout = ~rst & timeout_q;

`ifdef HAZ_PERF_EN
    logic [PERF_W-1:0] load_cnt;
    logic [PERF_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt <= '0;
            div_cnt  <= '0;
        end else begin
            if (stall_c == STALL_LOAD) load_cnt <= load_cnt + 1'b1;
            if (stall_c == STALL_DIV)  div_cnt  <= div_cnt + 1'b1;
        end
    end

    assign perf_load_stall = rst ? '0 : load_cnt;
    assign perf_div_stall  = rst ? '0 : div_cnt;
`else
    assign perf_load_stall = '0;
    assign perf_div_stall  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_LOAD = 6'b000111;
    localparam logic [5:0] S_DIV  = 6'b001111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_id = 1'b0;
    logic        ex_div_req = 1'b0;
    logic        div_ready = 1'b0;
    logic        div_start;
    logic        div_busy;
    logic        div_timeout;
    logic [5:0]  stall;
    logic [31:0] perf_load_stall;
    logic [31:0] perf_div_stall;

    pipe_hazard_ctrl #(.DIV_TIMEOUT(64), .CNT_W(7), .PERF_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_id     (stallreq_id),
        .ex_div_req      (ex_div_req),
        .div_ready       (div_ready),
        .div_start       (div_start),
        .div_busy        (div_busy),
        .div_timeout     (div_timeout),
        .stall           (stall),
        .perf_load_stall (perf_load_stall),
        .perf_div_stall  (perf_div_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, s, e, d;
        logic [5:0] st;
        logic       start, busy, to;
    } vec_t;

    typedef struct {
        string       tag;
        logic [5:0]  st;
        logic        start, busy, to;
        logic [31:0] pl, pd;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   n_start = 0;
    logic [31:0] m_load = 0;
    logic [31:0] m_div = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, then check mid-cycle.
    task automatic step(input string tag, input logic r, s, e, d,
                        input logic [5:0] st, input logic start, busy, to);
        exp_t x;
        exp_t y;
        @(posedge clk);
        #1;
        rst = r; stallreq_id = s; ex_div_req = e; div_ready = d;
        x.tag = tag; x.st = st; x.start = start; x.busy = busy; x.to = to;
`ifdef HAZ_PERF_EN
        x.pl = r ? 32'd0 : m_load;
        x.pd = r ? 32'd0 : m_div;
        if (r) begin
            m_load = 0; m_div = 0;
        end else begin
            if (st == S_LOAD) m_load++;
            if (st == S_DIV)  m_div++;
        end
`else
        x.pl = 32'd0;
        x.pd = 32'd0;
`endif
        sb.push_back(x);
        @(negedge clk);
        y = sb.pop_front();
        if (div_start === 1'b1) n_start++;
        chk({y.tag, ".stall"},       32'(stall),       32'(y.st));
        chk({y.tag, ".div_start"},   32'(div_start),   32'(y.start));
        chk({y.tag, ".div_busy"},    32'(div_busy),    32'(y.busy));
        chk({y.tag, ".div_timeout"}, 32'(div_timeout), 32'(y.to));
        chk({y.tag, ".perf_load"},   perf_load_stall,  y.pl);
        chk({y.tag, ".perf_div"},    perf_div_stall,   y.pd);
    endtask

    vec_t tbl[13];

    initial begin
        //          r     s     e     d     stall   start busy  to
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0}; // outputs 0 in reset
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, S_LOAD, 1'b0, 1'b0, 1'b0}; // load-use, one cycle
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, S_DIV,  1'b1, 1'b0, 1'b0}; // EX beats ID
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, S_DIV,  1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, S_DIV,  1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, S_LOAD, 1'b0, 1'b0, 1'b0}; // DIV_DONE
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, S_DIV,  1'b1, 1'b0, 1'b0}; // back-to-back div
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, S_DIV,  1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0}; // ex_div_req ignored
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, S_NONE, 1'b0, 1'b0, 1'b0}; // stray ready ignored
        tbl[12] = '{1'b0, 1'b0, 1'b0, 0,    S_NONE, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++)
            step($sformatf("vec%0d", i), tbl[i].r, tbl[i].s, tbl[i].e, tbl[i].d,
                 tbl[i].st, tbl[i].start, tbl[i].busy, tbl[i].to);
        chk("b2b.start_count", 32'(n_start), 32'd2);

        // Divide with ready on the 10th wait cycle: 11 DIV cycles, then release.
        n_start = 0;
        step("div10.start", 0, 0, 1, 0, S_DIV, 1, 0, 0);
        for (int i = 1; i <= 10; i++)
            step($sformatf("div10.w%0d", i), 0, 0, 1, (i == 10), S_DIV, 0, 1, 0);
        step("div10.done", 0, 0, 1, 0, S_NONE, 0, 0, 0);
        step("div10.idle", 0, 0, 0, 0, S_NONE, 0, 0, 0);
        chk("div10.start_count", 32'(n_start), 32'd1);

        // No div_ready: forced release after 64 wait cycles, sticky timeout.
        step("tmo.start", 0, 0, 1, 0, S_DIV, 1, 0, 0);
        for (int i = 0; i < 64; i++)
            step($sformatf("tmo.w%0d", i), 0, 0, 1, 0, S_DIV, 0, 1, 0);
        step("tmo.done", 0, 1, 1, 0, S_LOAD, 0, 0, 1);
        step("tmo.idle", 0, 0, 0, 1, S_NONE, 0, 0, 1);
        step("tmo.sticky", 0, 1, 0, 0, S_LOAD, 0, 0, 1);

        // Reset at the 5th wait cycle: outputs clear and the FSM returns to IDLE.
        step("rst.start", 0, 0, 1, 0, S_DIV, 1, 0, 1);
        for (int i = 1; i <= 4; i++)
            step($sformatf("rst.w%0d", i), 0, 0, 1, 0, S_DIV, 0, 1, 1);
        step("rst.assert", 1, 0, 1, 0, S_NONE, 0, 0, 0);
        step("rst.after", 0, 0, 0, 0, S_NONE, 0, 0, 0);
        step("rst.load", 0, 1, 0, 0, S_LOAD, 0, 0, 0);
        step("rst.end", 0, 0, 0, 0, S_NONE, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
